// File: rtl/hashtable_hit_merger.sv
// hashtable_hit_merger: merges the two hashtable hit lanes into one buffered
// valid/ready stream. Lanes cannot be stalled, so hits without space are
// dropped and counted; almost_full asks upstream to throttle.
// Optional build macro: HITMERGE_DEDUP_EN collapses identical same-cycle hits
// into a single lane0 entry.
module hashtable_hit_merger #(
  parameter int DWIDTH       = 16,
  parameter int DEPTH        = 32,
  parameter int AFULL_THRESH = 8,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DWIDTH-1:0]    in0_data,
  input  logic                 in0_valid,
  input  logic [DWIDTH-1:0]    in1_data,
  input  logic                 in1_valid,
  output logic [DWIDTH-1:0]    out_data,
  output logic                 out_lane,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 almost_full,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic                 overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C  = (AW+1)'(DEPTH);
  localparam logic [AW:0] THRESH_C = (AFULL_THRESH >= DEPTH) ? DEPTH_C : (AW+1)'(AFULL_THRESH);

  // Saturating add of this cycle's drops into the drop counter.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] acc,
                                                   input logic [1:0] inc);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, acc} + {{(CNT_WIDTH-1){1'b0}}, inc};
    return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
  endfunction

  // Entry layout: {lane, data}
  logic [DWIDTH:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr, wr1_addr;
  logic [AW:0]     count, count_next, free, free_next;
  logic            dup, lane1_req, wr0_en, wr1_en, pop;
  logic [1:0]      drops;

  // Push/drop decision from start-of-cycle free space; a same-cycle pop
  // never makes room for a same-cycle push.
  always_comb begin
    dup = 1'b0;
`ifdef HITMERGE_DEDUP_EN
    dup = in0_valid && in1_valid && (in0_data == in1_data);
`endif
    lane1_req = in1_valid && !dup;
    free      = DEPTH_C - count;
    wr0_en    = 1'b0;
    wr1_en    = 1'b0;
    drops     = 2'd0;
    if (!rst) begin
      if (in0_valid && lane1_req) begin
        if (free >= (AW+1)'(2)) begin
          wr0_en = 1'b1;
          wr1_en = 1'b1;
        end else if (free == (AW+1)'(1)) begin
          wr0_en = 1'b1;
          drops  = 2'd1;
        end else begin
          drops  = 2'd2;
        end
      end else if (in0_valid) begin
        if (free != '0) wr0_en = 1'b1;
        else            drops  = 2'd1;
      end else if (lane1_req) begin
        if (free != '0) wr1_en = 1'b1;
        else            drops  = 2'd1;
      end
    end
    wr1_addr   = wr_ptr + {{(AW-1){1'b0}}, wr0_en};
    pop        = (count != '0) && out_ready;
    count_next = count + {{AW{1'b0}}, wr0_en} + {{AW{1'b0}}, wr1_en} - {{AW{1'b0}}, pop};
    free_next  = DEPTH_C - count_next;
  end

  // Entry storage; lane0 lands ahead of lane1 to keep same-cycle order.
  always_ff @(posedge clk) begin
    if (wr0_en) mem[wr_ptr]   <= {1'b0, in0_data};
    if (wr1_en) mem[wr1_addr] <= {1'b1, in1_data};
  end

  // Pointers, occupancy, throttle flag and drop bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
      drop_cnt    <= '0;
      overflow    <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + {{(AW-1){1'b0}}, wr0_en} + {{(AW-1){1'b0}}, wr1_en};
      rd_ptr      <= rd_ptr + {{(AW-1){1'b0}}, pop};
      count       <= count_next;
      almost_full <= (free_next <= THRESH_C);
      drop_cnt    <= sat_add(drop_cnt, drops);
      overflow    <= overflow | (drops != 2'd0);
    end
  end

  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr][DWIDTH-1:0];
  assign out_lane  = mem[rd_ptr][DWIDTH];

endmodule
